runlen_share_arbiter: RTL
=========================

// Module: runlen_share_arbiter
// PURPOSE
//   Shares one run-length tracking engine between NUM_REQ byte streams. Each stream's bit0 runs are tracked.
//   Round-robin grants one beat per cycle; per-requester context (current run, longest run) held in regs.
//   On a frame's last beat the requester's longest run is posted to a single-entry result port.
//   Sits between the ingress byte streams and the statistics collector.
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..8)
//   DATA_W   8   bytes per beat width; only bit 0 is examined
//   CNT_W    4   run counter width; counters saturate at 2**CNT_W-1
// PORTS
//   clk            in   1               clock
//   reset          in   1               synchronous, active-high
//   req_valid      in   NUM_REQ         beat offered by requester i
//   req_data       in   NUM_REQ*DATA_W  beat data, requester i at [i*DATA_W +: DATA_W]
//   req_last       in   NUM_REQ         beat is last of frame
//   req_ready      out  NUM_REQ         one-hot grant; beat consumed when valid&ready
//   res_valid      out  1               result pending
//   res_ready      in   1               result accepted when valid&ready
//   res_id         out  $clog2(NUM_REQ) requester that finished the frame
//   res_max        out  CNT_W           longest run of bit0==1 in that frame
//   res_frame_len  out  8               beats in frame (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (sync, active-high): all contexts cur=max=0; rr pointer=0; res_valid=0.
//     Reset also sets res_id=0, res_max=0, res_frame_len=0 and req_ready=0. Reset mid-frame discards all partial frames.
//   - Eligible(i) = req_valid[i] & ~(req_last[i] & res_valid & ~res_ready).
//   - Grant: the first eligible requester at or after the pointer, cyclic. At most one req_ready bit is high.
//     req_ready is combinational from eligibility and the pointer. It is 0 during reset.
//   - Pointer: after a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
//   - Granted non-last beat, context i:
//       bit0=1 -> cur <= sat_inc(cur). bit0=0 -> cur <= 0.
//       max <= max(max, new cur).
//   - Granted last beat: compute new cur/max as above.
//     Next cycle: res_valid=1, res_id=i, res_max=new max. Context i is then cleared to cur=max=0.
//     Latency is 1 cycle from the last-beat handshake to res_valid.
//   - Result register: it holds until res_valid&res_ready.
//     An accept and a new last-beat grant in the same cycle are allowed; the register reloads and res_valid stays 1.
//   - Non-last beats are never blocked by a pending result. Only last beats stall.
//   - Saturation: cur stays at 2**CNT_W-1 on further 1s. It never wraps.
//   - A single-beat frame (last on first beat) gives res_max = bit0 ? 1 : 0.
//   - Non-granted requesters' contexts are unchanged.
// CONFIGURATION
//   RUNLEN_ARB_FRAME_LEN_EN defined:
//     A per-requester 8-bit beat counter, saturating at 255 and including the last beat.
//     It is posted as res_frame_len with the result and cleared with the context.
//   Not defined: no beat counters; res_frame_len is tied to 0. The port is always present.
// STRUCTURE
//   Package runlen_arb_pkg: CNT_W default; typedef struct {cur, max} runlen_ctx_t.
//   The package also holds function sat_inc(); and localparam FRAME_LEN_W=8.
//   Sub-module runlen_rr_pick: a parameterised round-robin picker.
//   Its inputs are eligible and pointer; its outputs are one-hot grant and grant index.
// TESTING
//   1 Reset: assert reset 2 cycles with all req_valid=1.
//     -> req_ready=0, res_valid=0. After release, requester 0 is granted first.
//   2 Single requester 0: bits 1,1,0,1,1,1, last on the 6th beat.
//     -> 1 cycle later res_valid=1, res_id=0, res_max=3. Frame_len=6 if the macro is defined.
//   3 All 4 requesters valid continuously.
//     -> grants cycle 0,1,2,3,0...; each requester gets 1 of every 4 cycles.
//   4 Result held (res_ready=0) while req 1 presents last and req 2 presents non-last.
//     -> req 1 is stalled and req 2 is granted. Raising res_ready lets req 1 post next cycle with res_id=1.
//   5 Requester 3: 20 beats of bit0=1, then last. -> res_max=15 (saturated, no wrap).
//   6 Reset asserted mid-frame on req 2 (cur=5), then a new frame 1,0,1 with last.
//     -> res_max=1; the old context is discarded.

Source files
------------

// File: rtl/runlen_share_arbiter_pkg.sv
// Shared types and helpers for the run-length share arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//   RUNLEN_CNT_W : run counter width; counters saturate at 2**RUNLEN_CNT_W-1
//   FRAME_LEN_W  : width of the optional per-frame beat counter
package runlen_arb_pkg;

    localparam int RUNLEN_CNT_W = 4;
    localparam int FRAME_LEN_W  = 8;

    // Per-requester tracking context: current run of ones and longest so far.
    typedef struct packed {
        logic [RUNLEN_CNT_W-1:0] cur;
        logic [RUNLEN_CNT_W-1:0] max;
    } runlen_ctx_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RUNLEN_CNT_W-1:0] sat_inc(input logic [RUNLEN_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/runlen_share_arbiter_if.sv
// Bundle of requester streams plus the single-entry result port.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, res_valid/res_ready on results.
//   master : the ingress side / statistics collector (drives beats and res_ready)
//   slave  : the arbiter (drives grants and the result)
interface runlen_share_arbiter_if
    import runlen_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = RUNLEN_CNT_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic [IDX_W-1:0]          res_id;
    logic [CNT_W-1:0]          res_max;
    logic [FRAME_LEN_W-1:0]    res_frame_len;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_id, res_max, res_frame_len
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_id, res_max, res_frame_len
    );
endinterface

// File: rtl/runlen_share_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, cyclic.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when nothing is eligible.
//   eligible  : per-requester request mask
//   ptr       : highest-priority requester this cycle
//   grant     : one-hot grant, grant_idx its index, grant_vld any grant
module runlen_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest eligible
    // requester (lowest offset from ptr) is the one left standing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_vld  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/runlen_share_arbiter.sv
// Shares one bit0 run-length engine across NUM_REQ streams, posting each frame's longest run.
// Latency: result valid 1 cycle after the last-beat handshake; grants are combinational.
// Backpressure: only last beats stall while an unaccepted result is pending; non-last beats flow.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : req_valid/req_data/req_last/req_ready per requester,
//                     res_valid/res_ready/res_id/res_max/res_frame_len result port
//   RUNLEN_ARB_FRAME_LEN_EN : when defined, res_frame_len carries the frame's beat
//                     count (saturating at 255); otherwise it is tied to 0.
module runlen_share_arbiter
    import runlen_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    runlen_share_arbiter_if.slave bus
);
    localparam int CNT_W = RUNLEN_CNT_W;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] bit0_vec;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;

    runlen_ctx_t        ctx [NUM_REQ];
    runlen_ctx_t        sel_ctx;
    logic               sel_last;
    logic [CNT_W-1:0]   new_cur;
    logic [CNT_W-1:0]   new_max;

    logic               res_valid_q;
    logic [IDX_W-1:0]   res_id_q;
    logic [CNT_W-1:0]   res_max_q;

    // Only bit 0 of each beat matters; the rest is folded away here.
    logic unused_data_bits;
    assign unused_data_bits = ^bus.req_data;

    // A last beat may only go when the result slot is free this cycle,
    // either empty or being drained by the collector right now.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign bit0_vec[i] = bus.req_data[i*DATA_W];
        assign eligible[i] = ~reset & bus.req_valid[i]
                           & ~(bus.req_last[i] & res_valid_q & ~bus.res_ready);
    end

    runlen_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_ctx  = ctx[grant_idx];
        sel_last = bus.req_last[grant_idx];
        new_cur  = bit0_vec[grant_idx] ? sat_inc(sel_ctx.cur) : '0;
        new_max  = (new_cur > sel_ctx.max) ? new_cur : sel_ctx.max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ctx[i] <= '0;
            end
            ptr         <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_max_q   <= '0;
        end else begin
            if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (grant_vld) begin
                ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                if (sel_last) begin
                    // Overrides the clear above when accept and reload coincide.
                    res_valid_q    <= 1'b1;
                    res_id_q       <= grant_idx;
                    res_max_q      <= new_max;
                    ctx[grant_idx] <= '0;
                end else begin
                    ctx[grant_idx].cur <= new_cur;
                    ctx[grant_idx].max <= new_max;
                end
            end
        end
    end

`ifdef RUNLEN_ARB_FRAME_LEN_EN
    logic [FRAME_LEN_W-1:0] flen [NUM_REQ];
    logic [FRAME_LEN_W-1:0] new_len;
    logic [FRAME_LEN_W-1:0] res_len_q;

    always_comb begin
        new_len = (flen[grant_idx] == '1) ? flen[grant_idx] : flen[grant_idx] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                flen[i] <= '0;
            end
            res_len_q <= '0;
        end else if (grant_vld) begin
            if (sel_last) begin
                flen[grant_idx] <= '0;
                res_len_q       <= new_len;
            end else begin
                flen[grant_idx] <= new_len;
            end
        end
    end

    assign bus.res_frame_len = res_len_q;
`else
    assign bus.res_frame_len = '0;
`endif

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_max   = res_max_q;
endmodule
